// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, with borrow-out Bout.
// Purely combinational; the serial datapath reuses a single instance each cycle.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               brw_q, brw_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fs_d;
  logic fs_bout;

  // Operands shift right every RUN cycle, so bit 0 is always the bit in flight.
  full_subtractor u_fs (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (brw_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; without this, synthesis infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        brw_d             = fs_bout;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = fs_d;
        cnt_d             = cnt_q + CNT_W'(1);
        // Results become visible only when the final (MSB) bit completes.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          d_d     = res_d;
          bout_d  = fs_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the last bit a_q[0]/b_q[0] hold the original sign bits.
          ovf_d   = (a_q[0] != b_q[0]) && (fs_d != a_q[0]);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results and completion cycles; a negedge monitor pops and compares on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("d", 64'(d), 64'(e.d));
        check("bout", 64'(bout), 64'(e.bout));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
  end

  // Accept edge is the next posedge (cyc+1); done is seen W edges later.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    @(negedge clk);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    e.d = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("idle_timeout", 64'(sb.size()) + 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d", 64'(d), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Basic subtraction; busy must be high right after acceptance.
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    check("busy_run", 64'(busy), 64'd1);
    wait_idle();

    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    wait_idle();

    // Start re-pulsed mid-RUN with new operands must not disturb the result.
    issue(8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during RUN aborts: outputs clear and no done pulse follows.
    @(negedge clk);
    a     = 8'h50;
    b     = 8'h20;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_d", 64'(d), 64'd0);
    check("abort_bout", 64'(bout), 64'd0);
    repeat (15) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);

    // Start held high: three back-to-back operations, done pulses 10 apart.
    @(negedge clk);
    a     = 8'hC8;
    b     = 8'h35;
    bin   = 1'b0;
    start = 1'b1;
    k     = cyc + 1;
    e.d = 8'h93; e.bout = 1'b0; e.ovf = 1'b0; e.cyc = k + W;      sb.push_back(e);
    e.d = 8'hDE; e.bout = 1'b1; e.ovf = 1'b0; e.cyc = k + W + 10; sb.push_back(e);
    e.d = 8'hFF; e.bout = 1'b1; e.ovf = 1'b0; e.cyc = k + W + 20; sb.push_back(e);
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    repeat (10) @(negedge clk);
    a   = 8'h7F;
    b   = 8'h7F;
    bin = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    bin   = 1'b0;
    wait_idle();

    // Boundaries and signed-overflow cases.
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    issue(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    wait_idle();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_idle();
    issue(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on accepted start.
REQ-006 b  input  WIDTH  subtrahend; sampled on accepted start.
REQ-007 bin  input  1  borrow-in; sampled on accepted start.
REQ-008 d  output  WIDTH  difference a - b - bin, registered.
REQ-009 bout  output  1  borrow-out of MSB, registered.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse when d/bout are valid.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 IDLE->RUN on a rising clk edge with start=1: latch a, b, bin; clear the bit counter.
REQ-014 In RUN, each edge SHALL process bit index cnt, LSB first, computing D=a^b^brw and brw'=(~a&b)|(~(a^b)&brw), then shift the result into d and increment cnt.
REQ-015 RUN->DONE on the edge that processes bit WIDTH-1; exactly WIDTH cycles are spent in RUN.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high during cycle k+WIDTH+1.
REQ-018 d and bout SHALL be updated only at the end of RUN; they hold their value until the next completion or reset.
REQ-019 While busy=1, start SHALL be ignored and a/b/bin SHALL not be resampled.
REQ-020 Start asserted in the DONE cycle SHALL be ignored; start held high through IDLE SHALL launch back-to-back operations.
REQ-021 All arithmetic is modulo 2^WIDTH; bout=1 iff a < b+bin (unsigned).
REQ-022 The counter width SHALL be $clog2(WIDTH+1); no wrap occurs before the RUN->DONE transition.

Reset
REQ-023 On reset=1 at a clk edge: state=IDLE, d=0, bout=0, busy=0, done=0, counter=0, internal operand and borrow registers=0.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-025 Reset SHALL take priority over start on the same edge.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, add output ovf (1 bit, registered, reset 0), set with d to signed two's-complement overflow (a[MSB]!=b[MSB] && d[MSB]!=a[MSB]).
REQ-027 Without SERIAL_SUBTRACTOR_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package serial_sub_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The per-bit logic SHALL be a sub-module, full_subtractor (A, B, Bin -> D, Bout), instantiated once and reused every RUN cycle.

Verification (WIDTH=8)
REQ-030 a=8'h05, b=8'h03, bin=0, start pulse: the bench SHALL see d=8'h02, bout=0, done high exactly 9 cycles after the start edge.
REQ-031 a=8'h00, b=8'h01, bin=0: the bench SHALL see d=8'hFF, bout=1; a=8'h10, b=8'h0F, bin=1: d=8'h00, bout=0.
REQ-032 start re-pulsed with a=8'hAA mid-RUN: the bench SHALL see that it is ignored and that the original result and timing are unchanged.
REQ-033 reset asserted at RUN cycle 4: the bench SHALL see busy=0, d=0, bout=0 on the next cycle and no done pulse.
REQ-034 start held high for 3 operations: the bench SHALL see done pulses 10 cycles apart, with correct results each time.
REQ-035 With OVF_EN defined, a=8'h80, b=8'h01: the bench SHALL see d=8'h7F, ovf=1, bout=0; with a=8'h05, b=8'h03: ovf=0.
